// File: rtl/key_sequence_capture_if.sv
// Key-entry bus: one-hot key pulses and clear in, assembled code and status pulses out.
interface key_sequence_capture_if #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned KEY_BITS = 2,
    parameter int unsigned DIGITS   = 4
);
    localparam int unsigned CODE_W = DIGITS * KEY_BITS;
    localparam int unsigned CNT_W  = $clog2(DIGITS + 1);

    logic [WIDTH-1:0]  keyEdge;
    logic              clear;
    logic [CODE_W-1:0] code;
    logic [CNT_W-1:0]  digitCount;
    logic              entering;
    logic              codeValid;
    logic              timeoutErr;

    modport master (
        output keyEdge, clear,
        input  code, digitCount, entering, codeValid, timeoutErr
    );

    modport slave (
        input  keyEdge, clear,
        output code, digitCount, entering, codeValid, timeoutErr
    );
endinterface

// File: rtl/key_sequence_capture.sv
// Collects single-key press pulses into a DIGITS-long code, with inactivity
// timeout and synchronous clear aborting a partial entry.
module key_sequence_capture #(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned KEY_BITS       = 2,
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                  clock,
    input  logic                  reset,
    key_sequence_capture_if.slave bus
);
    localparam int unsigned CODE_W = DIGITS * KEY_BITS;
    localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
    localparam int unsigned TMR_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ENTRY = 1'b1;

    logic [0:0]        r_state;
    logic [CODE_W-1:0] r_code;
    logic [CNT_W-1:0]  r_cnt;
    logic [TMR_W-1:0]  r_timer;
    logic              r_valid;
    logic              r_terr;

    logic [0:0]        w_state_nxt;
    logic [CODE_W-1:0] w_code_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [TMR_W-1:0]  w_timer_nxt;
    logic              w_valid_nxt;
    logic              w_terr_nxt;

    logic              w_press;
    logic [KEY_BITS-1:0] w_idx;
    logic [CNT_W-1:0]  w_cnt_inc;

    // Multi-key chords are not presses at all: they neither store nor restart the timer
    assign w_press   = $onehot(bus.keyEdge);
    assign w_cnt_inc = (r_state == S_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.keyEdge[i]) w_idx = KEY_BITS'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_cnt_nxt   = r_cnt;
        w_timer_nxt = r_timer;
        w_valid_nxt = 1'b0;
        w_terr_nxt  = 1'b0;

        if (bus.clear) begin
            w_state_nxt = S_IDLE;
            w_code_nxt  = '0;
            w_cnt_nxt   = '0;
            w_timer_nxt = '0;
        end else if (w_press) begin
            // A press from IDLE discards any previously completed code
            w_code_nxt  = (r_state == S_IDLE) ? CODE_W'(w_idx)
                                              : (r_code << KEY_BITS) | CODE_W'(w_idx);
            w_cnt_nxt   = w_cnt_inc;
            w_timer_nxt = '0;
            if (w_cnt_inc == CNT_W'(DIGITS)) begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b1;
            end else begin
                w_state_nxt = S_ENTRY;
            end
        end else if (r_state == S_ENTRY) begin
            if (r_timer == TMR_W'(TIMEOUT_CYCLES - 2)) begin
                w_state_nxt = S_IDLE;
                w_code_nxt  = '0;
                w_cnt_nxt   = '0;
                w_timer_nxt = '0;
                w_terr_nxt  = 1'b1;
            end else begin
                w_timer_nxt = r_timer + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_code  <= '0;
            r_cnt   <= '0;
            r_timer <= '0;
            r_valid <= 1'b0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_cnt   <= w_cnt_nxt;
            r_timer <= w_timer_nxt;
            r_valid <= w_valid_nxt;
            r_terr  <= w_terr_nxt;
        end
    end

    assign bus.code       = r_code;
    assign bus.digitCount = r_cnt;
    assign bus.entering   = (r_state == S_ENTRY);
    assign bus.codeValid  = r_valid;
    assign bus.timeoutErr = r_terr;
endmodule

// File: tb/tb_key_sequence_capture.sv
// Bench for key_sequence_capture: directed scenarios plus randomized traffic
// compared cycle by cycle against a digit-list reference model.
module tb_key_sequence_capture;
    localparam int unsigned WIDTH    = 4;
    localparam int unsigned KEY_BITS = 2;
    localparam int unsigned DIGITS   = 4;
    localparam int unsigned TMO      = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;

    key_sequence_capture_if #(.WIDTH(WIDTH), .KEY_BITS(KEY_BITS), .DIGITS(DIGITS)) bus ();

    key_sequence_capture #(
        .WIDTH(WIDTH), .KEY_BITS(KEY_BITS), .DIGITS(DIGITS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the entry is a list of digits plus an idle-cycle count
    int m_digits[$];
    bit m_entry;
    int m_idle;
    bit m_valid;
    bit m_terr;

    function automatic void model_reset();
        m_digits.delete();
        m_entry = 1'b0;
        m_idle  = 0;
        m_valid = 1'b0;
        m_terr  = 1'b0;
    endfunction

    function automatic void model_step(input logic [3:0] ke, input bit clr);
        int idx;
        m_valid = 1'b0;
        m_terr  = 1'b0;
        idx = 0;
        for (int i = 0; i < 4; i++) if (ke[i]) idx = i;
        if (clr) begin
            m_digits.delete();
            m_entry = 1'b0;
            m_idle  = 0;
        end else if ($countones(ke) == 1) begin
            if (!m_entry) m_digits.delete();
            m_digits.push_back(idx);
            m_idle = 0;
            if (m_digits.size() == DIGITS) begin
                m_entry = 1'b0;
                m_valid = 1'b1;
            end else begin
                m_entry = 1'b1;
            end
        end else if (m_entry) begin
            m_idle++;
            if (m_idle == TMO - 1) begin
                m_digits.delete();
                m_entry = 1'b0;
                m_idle  = 0;
                m_terr  = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] model_code();
        int c;
        c = 0;
        foreach (m_digits[k]) c = c * 4 + m_digits[k];
        return 8'(c % 256);
    endfunction

    function automatic logic [13:0] model_vec();
        return {model_code(), 3'(m_digits.size()), m_entry, m_valid, m_terr};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {bus.code, bus.digitCount, bus.entering, bus.codeValid, bus.timeoutErr};
    endfunction

    task automatic tick(input logic [3:0] ke, input bit clr);
        bus.keyEdge = ke;
        bus.clear   = clr;
        @(posedge clock);
        model_step(ke, clr);
        #1;
        bus.keyEdge = '0;
        bus.clear   = 1'b0;
    endtask

    task automatic test_reset();
        bus.keyEdge = '0;
        bus.clear   = 1'b0;
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if (bus.code !== 8'h00) $display("FAIL reset_code: got %h expected 00", bus.code); else n_pass++;
        n_checks++;
        if (bus.digitCount !== 3'd0) $display("FAIL reset_cnt: got %0d expected 0", bus.digitCount); else n_pass++;
        n_checks++;
        if (bus.entering !== 1'b0) $display("FAIL reset_entering: got %b expected 0", bus.entering); else n_pass++;
        n_checks++;
        if (bus.codeValid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.codeValid); else n_pass++;
        n_checks++;
        if (bus.timeoutErr !== 1'b0) $display("FAIL reset_terr: got %b expected 0", bus.timeoutErr); else n_pass++;
    endtask

    task automatic test_basic_code();
        int keys[4] = '{2, 0, 3, 1};
        int nvalid = 0;
        for (int d = 0; d < 4; d++) begin
            for (int s = 0; s < 3; s++) begin
                tick((s == 0) ? 4'(1 << keys[d]) : 4'b0, 1'b0);
                if (bus.codeValid === 1'b1) nvalid++;
                n_checks++;
                if (obs_vec() !== model_vec())
                    $display("FAIL basic d%0d s%0d: got %h expected %h", d, s, obs_vec(), model_vec());
                else n_pass++;
                if (d == 3 && s == 0) begin
                    n_checks++;
                    if (bus.code !== 8'h8D || bus.codeValid !== 1'b1)
                        $display("FAIL basic_final: got code %h valid %b expected 8D 1", bus.code, bus.codeValid);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (nvalid != 1 || bus.entering !== 1'b0 || bus.digitCount !== 3'd4)
            $display("FAIL basic_pulses: got valid %0d entering %b cnt %0d expected 1 0 4",
                     nvalid, bus.entering, bus.digitCount);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int terr_at = -1;
        int nvalid = 0;
        tick(4'b0010, 1'b0);
        tick(4'b0000, 1'b0);
        tick(4'b0010, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            tick(4'b0000, 1'b0);
            if (bus.timeoutErr === 1'b1) terr_at = (terr_at < 0) ? k : 99;
            if (bus.codeValid === 1'b1) nvalid++;
            n_checks++;
            if (obs_vec() !== model_vec())
                $display("FAIL timeout k%0d: got %h expected %h", k, obs_vec(), model_vec());
            else n_pass++;
        end
        n_checks++;
        if (terr_at != 15 || nvalid != 0 || bus.code !== 8'h00 || bus.digitCount !== 3'd0)
            $display("FAIL timeout_sched: got terr_at %0d valid %0d code %h cnt %0d expected 15 0 00 0",
                     terr_at, nvalid, bus.code, bus.digitCount);
        else n_pass++;
    endtask

    task automatic test_multi_bit();
        int terr_at = -1;
        tick(4'b1000, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            tick((k == 5) ? 4'b0101 : 4'b0000, 1'b0);
            if (bus.timeoutErr === 1'b1) terr_at = (terr_at < 0) ? k : 99;
            if (k == 5) begin
                n_checks++;
                if (bus.digitCount !== 3'd1 || bus.code !== 8'h03)
                    $display("FAIL multi_ignored: got cnt %0d code %h expected 1 03", bus.digitCount, bus.code);
                else n_pass++;
            end
            n_checks++;
            if (obs_vec() !== model_vec())
                $display("FAIL multi k%0d: got %h expected %h", k, obs_vec(), model_vec());
            else n_pass++;
        end
        n_checks++;
        if (terr_at != 15) $display("FAIL multi_timeout: got terr_at %0d expected 15", terr_at);
        else n_pass++;
    endtask

    task automatic test_clear_last();
        tick(4'b0001, 1'b0);
        tick(4'b0010, 1'b0);
        tick(4'b0100, 1'b0);
        tick(4'b1000, 1'b1);
        n_checks++;
        if (bus.codeValid !== 1'b0 || bus.code !== 8'h00 || bus.digitCount !== 3'd0 || bus.entering !== 1'b0)
            $display("FAIL clear_last: got valid %b code %h cnt %0d entering %b expected 0 00 0 0",
                     bus.codeValid, bus.code, bus.digitCount, bus.entering);
        else n_pass++;
        tick(4'b0000, 1'b0);
        n_checks++;
        if (obs_vec() !== model_vec()) $display("FAIL clear_after: got %h expected %h", obs_vec(), model_vec());
        else n_pass++;
    endtask

    task automatic test_press_on_expiry();
        tick(4'b0010, 1'b0);
        repeat (14) tick(4'b0000, 1'b0);
        tick(4'b0100, 1'b0);
        n_checks++;
        if (bus.timeoutErr !== 1'b0 || bus.digitCount !== 3'd2 || bus.code !== 8'h06 || bus.entering !== 1'b1)
            $display("FAIL expiry_press: got terr %b cnt %0d code %h entering %b expected 0 2 06 1",
                     bus.timeoutErr, bus.digitCount, bus.code, bus.entering);
        else n_pass++;
        tick(4'b0000, 1'b1);
        n_checks++;
        if (obs_vec() !== model_vec()) $display("FAIL expiry_clear: got %h expected %h", obs_vec(), model_vec());
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int keys[4] = '{1, 3, 0, 2};
        int nvalid = 0;
        tick(4'b1000, 1'b0);
        tick(4'b0100, 1'b0);
        tick(4'b0010, 1'b0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (obs_vec() !== 14'h0) $display("FAIL async_reset: got %h expected 0000", obs_vec());
        else n_pass++;
        #2 reset = 1'b1;
        for (int d = 0; d < 4; d++) begin
            tick(4'(1 << keys[d]), 1'b0);
            if (bus.codeValid === 1'b1) nvalid++;
            tick(4'b0000, 1'b0);
        end
        n_checks++;
        if (bus.code !== 8'h72 || nvalid != 1)
            $display("FAIL async_fresh: got code %h valid %0d expected 72 1", bus.code, nvalid);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] multi[11] = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC, 4'h7, 4'hB, 4'hD, 4'hE, 4'hF};
        int errs = 0;
        for (int blk = 0; blk < 24; blk++) begin
            int rate = (blk % 2 == 1) ? 35 : 5;
            for (int c = 0; c < 40; c++) begin
                int r = int'($urandom_range(0, 99));
                logic [3:0] ke = 4'b0;
                bit clr = 1'b0;
                if (r < rate) ke = 4'(1 << $urandom_range(0, 3));
                else if (r < rate + 3) ke = multi[$urandom_range(0, 10)];
                else if (r < rate + 4) clr = 1'b1;
                else if (r < rate + 5) begin
                    ke  = 4'(1 << $urandom_range(0, 3));
                    clr = 1'b1;
                end
                tick(ke, clr);
                n_checks++;
                if (obs_vec() !== model_vec()) begin
                    if (errs < 10)
                        $display("FAIL random b%0d c%0d: got %h expected %h", blk, c, obs_vec(), model_vec());
                    errs++;
                end else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_code();
        test_timeout();
        test_multi_bit();
        test_clear_last();
        test_press_on_expiry();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
